// File: rtl/fpu_pkg.sv
// Shared FPU constants: rounding modes, rounder decisions, special-case selects,
// exception-flag bit positions and the canonical quiet-NaN pieces.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [1:0] RO_NONE = 2'b00;
    localparam logic [1:0] RO_INC  = 2'b01;
    localparam logic [1:0] RO_DEC  = 2'b11;

    localparam logic [1:0] SP_NORMAL = 2'b00;
    localparam logic [1:0] SP_QNAN   = 2'b01;
    localparam logic [1:0] SP_INF    = 2'b10;
    localparam logic [1:0] SP_ZERO   = 2'b11;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Canonical qNaN: positive sign, all-ones exponent, only the quiet bit set.
    localparam logic QNAN_SIGN      = 1'b0;
    localparam logic QNAN_QUIET_BIT = 1'b1;

    function automatic logic pre_inexact(input logic [1:0] rs, input logic [1:0] round_out);
        return (|rs) | (round_out != RO_NONE);
    endfunction

endpackage

// File: rtl/fpu_overflow_select.sv
// Chooses infinity versus max-finite on exponent overflow from rounding mode and sign.
module fpu_overflow_select
    import fpu_pkg::*;
(
    input  logic [2:0] rm_i,
    input  logic       sign_i,
    output logic       use_inf_o
);

    // Directed modes round toward infinity only on the matching sign.
    always_comb begin
        use_inf_o = 1'b1;
        case (rm_i)
            RM_RNE:  use_inf_o = 1'b1;
            RM_RMM:  use_inf_o = 1'b1;
            RM_RTZ:  use_inf_o = 1'b0;
            RM_RDN:  use_inf_o = sign_i;
            RM_RUP:  use_inf_o = ~sign_i;
            default: use_inf_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_add_sub_round_apply.sv
// Post-rounding stage of the add/sub datapath: applies the +/-1 ulp decision,
// renormalizes, resolves overflow, packs the IEEE-754 result and raises flags.
module fpu_add_sub_round_apply
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
)
(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     sign_i,
    input  logic [EXP_W+1:0]         exp_i,
    input  logic [MAN_W:0]           man_i,
    input  logic [2:0]               lrs_i,
    input  logic [1:0]               round_out_i,
    input  logic [2:0]               rm_i,
    input  logic [1:0]               special_i,
    input  logic                     nv_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic [4:0]               fflags_o
);

    localparam int EW = EXP_W + 2;
    localparam int W  = EXP_W + MAN_W + 1;

    localparam logic signed [EW-1:0] EXP_ZERO = {EW{1'b0}};
    localparam logic signed [EW-1:0] EXP_ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] EXP_OVF  = {2'b00, {EXP_W{1'b1}}};
    localparam logic [MAN_W+1:0]     ULP      = {{(MAN_W+1){1'b0}}, 1'b1};
    localparam logic [W-1:0]         QNAN     = {QNAN_SIGN, {EXP_W{1'b1}}, QNAN_QUIET_BIT,
                                                 {(MAN_W-1){1'b0}}};

    logic signed [EW-1:0] exp_s;
    logic [MAN_W+1:0]     m1_s;
    logic signed [EW-1:0] adj_exp_s;
    logic [MAN_W:0]       adj_man_s;
    logic                 unused_s;

    logic                 v1_r;
    logic                 s1_sign_r;
    logic signed [EW-1:0] s1_exp_r;
    logic [MAN_W-1:0]     s1_man_r;
    logic                 s1_nx_r;
    logic [2:0]           s1_rm_r;
    logic [1:0]           s1_special_r;
    logic                 s1_nv_r;

    logic                 v2_r;
    logic [W-1:0]         result_r;
    logic [4:0]           fflags_r;

    logic                 adv2_s;
    logic                 ready_s;
    logic                 use_inf_s;
    logic [W-1:0]         inf_s;
    logic [W-1:0]         max_s;
    logic [W-1:0]         norm_pack_s;
    logic [4:0]           norm_flags_s;
    logic [W-1:0]         pack_s;
    logic [4:0]           flags_s;

    assign exp_s    = $signed(exp_i);
    assign adv2_s   = ~v2_r | ready_i;
    assign ready_s  = ~v1_r | adv2_s;
    // The L bit only steers the rounder; the hidden bit is implied by the exponent.
    assign unused_s = ^{lrs_i[2], adj_man_s[MAN_W]};

    // Apply the ulp adjustment and renormalize on carry-out or borrow.
    always_comb begin
        case (round_out_i)
            RO_INC:  m1_s = {1'b0, man_i} + ULP;
            RO_DEC:  m1_s = {1'b0, man_i} - ULP;
            default: m1_s = {1'b0, man_i};
        endcase
        adj_exp_s = exp_s;
        adj_man_s = m1_s[MAN_W:0];
        if (m1_s[MAN_W+1]) begin
            adj_man_s = m1_s[MAN_W+1:1];
            adj_exp_s = exp_s + EXP_ONE;
        end else if (!m1_s[MAN_W] && (exp_s > EXP_ONE)) begin
            adj_man_s = {m1_s[MAN_W-1:0], 1'b1};
            adj_exp_s = exp_s - EXP_ONE;
        end else if (!m1_s[MAN_W] && (exp_s == EXP_ONE)) begin
            adj_exp_s = EXP_ZERO;
        end else if (m1_s[MAN_W] && (exp_s == EXP_ZERO)) begin
            adj_exp_s = EXP_ONE;
        end else begin
            adj_exp_s = exp_s;
            adj_man_s = m1_s[MAN_W:0];
        end
    end

    fpu_overflow_select u_ovf_sel (
        .rm_i      (s1_rm_r),
        .sign_i    (s1_sign_r),
        .use_inf_o (use_inf_s)
    );

    assign inf_s = {s1_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign max_s = {s1_sign_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    // Pack a non-special result: overflow, zero/subnormal exponent field, or normal.
    always_comb begin
        norm_flags_s          = 5'b00000;
        norm_flags_s[FLAG_NV] = s1_nv_r;
        norm_flags_s[FLAG_DZ] = 1'b0;
        if (s1_exp_r >= EXP_OVF) begin
            norm_pack_s           = use_inf_s ? inf_s : max_s;
            norm_flags_s[FLAG_OF] = 1'b1;
            norm_flags_s[FLAG_NX] = 1'b1;
        end else if (s1_exp_r <= EXP_ZERO) begin
            norm_pack_s           = {s1_sign_r, {EXP_W{1'b0}}, s1_man_r};
            norm_flags_s[FLAG_NX] = s1_nx_r;
            norm_flags_s[FLAG_UF] = s1_nx_r;
        end else begin
            norm_pack_s           = {s1_sign_r, s1_exp_r[EXP_W-1:0], s1_man_r};
            norm_flags_s[FLAG_NX] = s1_nx_r;
        end
    end

    // Special-case overrides carry only the invalid flag.
    always_comb begin
        flags_s          = 5'b00000;
        flags_s[FLAG_NV] = s1_nv_r;
        case (s1_special_r)
            SP_NORMAL: begin
                pack_s  = norm_pack_s;
                flags_s = norm_flags_s;
            end
            SP_QNAN:   pack_s = QNAN;
            SP_INF:    pack_s = inf_s;
            SP_ZERO:   pack_s = {s1_sign_r, {(EXP_W+MAN_W){1'b0}}};
            default:   pack_s = QNAN;
        endcase
    end

    // Stage 1 register: loads whenever it is empty or stage 2 can take its beat.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v1_r         <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_exp_r     <= EXP_ZERO;
            s1_man_r     <= {MAN_W{1'b0}};
            s1_nx_r      <= 1'b0;
            s1_rm_r      <= 3'b000;
            s1_special_r <= 2'b00;
            s1_nv_r      <= 1'b0;
        end else if (ready_s) begin
            v1_r <= valid_i;
            if (valid_i) begin
                s1_sign_r    <= sign_i;
                s1_exp_r     <= adj_exp_s;
                s1_man_r     <= adj_man_s[MAN_W-1:0];
                s1_nx_r      <= pre_inexact(lrs_i[1:0], round_out_i);
                s1_rm_r      <= rm_i;
                s1_special_r <= special_i;
                s1_nv_r      <= nv_i;
            end
        end
    end

    // Stage 2 register: output payload is frozen while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v2_r     <= 1'b0;
            result_r <= {W{1'b0}};
            fflags_r <= 5'b00000;
        end else if (adv2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                result_r <= pack_s;
                fflags_r <= flags_s;
            end
        end
    end

    assign ready_o  = ready_s;
    assign valid_o  = v2_r;
    assign result_o = result_r;
    assign fflags_o = fflags_r;

endmodule

// File: tb/tb_fpu_add_sub_round_apply.sv
// Bench for the add/sub post-rounding stage: directed vector table, randomized
// streaming against a numeric reference model, and hand-written stall/reset sequences.
module tb_fpu_add_sub_round_apply;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [23:0] m;
        logic [2:0]  lrs;
        logic [1:0]  ro;
        logic [2:0]  rm;
        logic [1:0]  sp;
        logic        nv;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_i, valid_i, ready_o, sign_i, nv_i, valid_o, ready_i;
    logic [9:0]  exp_i;
    logic [23:0] man_i;
    logic [2:0]  lrs_i, rm_i;
    logic [1:0]  round_out_i, special_i;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] q_res[$];
    logic [4:0]  q_fl[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    fpu_add_sub_round_apply #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .sign_i(sign_i), .exp_i(exp_i), .man_i(man_i), .lrs_i(lrs_i),
        .round_out_i(round_out_i), .rm_i(rm_i), .special_i(special_i), .nv_i(nv_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .fflags_o(fflags_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Numeric reference: value-level ulp step, renormalization, then IEEE packing.
    function automatic void model(input logic s, input logic [9:0] e_in, input logic [23:0] man,
                                  input logic [2:0] lrs, input logic [1:0] ro, input logic [2:0] rm,
                                  input logic [1:0] sp, input logic nv,
                                  output logic [31:0] res, output logic [4:0] fl);
        int e, m;
        bit nx, inf;
        e  = int'($signed(e_in));
        m  = int'(man) + ((ro == 2'b01) ? 1 : (ro == 2'b11) ? -1 : 0);
        nx = (lrs[1:0] != 2'b00) || (ro != 2'b00);
        if (m >= (1 << 24)) begin
            m = m / 2;
            e = e + 1;
        end else if (m < (1 << 23) && e > 1) begin
            m = m * 2 + 1;
            e = e - 1;
        end else if (m < (1 << 23) && e == 1) begin
            e = 0;
        end else if (m >= (1 << 23) && e == 0) begin
            e = 1;
        end
        case (sp)
            2'b01: begin res = 32'h7FC00000; fl = {nv, 4'b0000}; end
            2'b10: begin res = {s, 8'hFF, 23'd0}; fl = {nv, 4'b0000}; end
            2'b11: begin res = {s, 31'd0}; fl = {nv, 4'b0000}; end
            default: begin
                if (e >= 255) begin
                    inf = (rm == 3'b001) ? 1'b0 : (rm == 3'b010) ? s : (rm == 3'b011) ? !s : 1'b1;
                    res = inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
                    fl  = {nv, 4'b0101};
                end else if (e <= 0) begin
                    res = {s, 8'd0, m[22:0]};
                    fl  = {nv, 2'b00, nx, nx};
                end else begin
                    res = {s, e[7:0], m[22:0]};
                    fl  = {nv, 3'b000, nx};
                end
            end
        endcase
    endfunction

    task automatic add(input logic s, input logic [9:0] e, input logic [23:0] m, input logic [2:0] lrs,
                       input logic [1:0] ro, input logic [2:0] rm, input logic [1:0] sp, input logic nv,
                       input logic [31:0] res, input logic [4:0] fl);
        vec_t v;
        v.s = s; v.e = e; v.m = m; v.lrs = lrs; v.ro = ro; v.rm = rm;
        v.sp = sp; v.nv = nv; v.res = res; v.fl = fl;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        valid_i = 1'b1; sign_i = v.s; exp_i = v.e; man_i = v.m; lrs_i = v.lrs;
        round_out_i = v.ro; rm_i = v.rm; special_i = v.sp; nv_i = v.nv;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        int   cat;
        cat   = int'($urandom_range(0, 4));
        v.s   = 1'($urandom);
        v.lrs = 3'($urandom);
        v.ro  = 2'($urandom);
        v.rm  = 3'($urandom_range(0, 7));
        v.sp  = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom);
        v.nv  = 1'($urandom);
        case (cat)
            0: begin v.e = 10'($urandom_range(1, 254)); v.m = {1'b1, 23'($urandom)}; end
            1: begin
                v.e = 10'($urandom_range(253, 256));
                v.m = {1'b1, ($urandom_range(0, 1) != 0) ? 23'h7FFFFF : 23'($urandom)};
            end
            2: begin v.e = 10'd0; v.m = {1'b0, 23'($urandom)} | 24'd1; end
            3: begin v.e = 10'($urandom_range(1, 2)); v.m = 24'h800000; end
            default: begin v.e = 10'(-int'($urandom_range(1, 4))); v.m = {1'b0, 23'($urandom)} | 24'd1; end
        endcase
        v.res = 32'd0;
        v.fl  = 5'd0;
        return v;
    endfunction

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    logic        hold_prev = 1'b0;
    logic [31:0] held_res, er;
    logic [4:0]  held_fl, ef;
    always @(negedge clk) begin
        if (reset_i !== 1'b0) begin
            q_res.delete();
            q_fl.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && valid_o) begin
                check("hold_result", result_o, held_res);
                check("hold_flags", {27'd0, fflags_o}, {27'd0, held_fl});
            end
            hold_prev = valid_o && !ready_i;
            held_res  = result_o;
            held_fl   = fflags_o;
            if (valid_o && ready_i) begin
                if (q_res.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    er = q_res.pop_front();
                    ef = q_fl.pop_front();
                    check("sb_result", result_o, er);
                    check("sb_flags", {27'd0, fflags_o}, {27'd0, ef});
                end
            end
            if (valid_i && ready_o) begin
                model(sign_i, exp_i, man_i, lrs_i, round_out_i, rm_i, special_i, nv_i, er, ef);
                q_res.push_back(er);
                q_fl.push_back(ef);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] rdy_pat, exp_rdy, exp_vld;
        vec_t       bv[4];
        vec_t       v;
        int         n, k, emitted;

        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; sign_i = 1'b0; exp_i = 10'd0;
        man_i = 24'd0; lrs_i = 3'd0; round_out_i = 2'd0; rm_i = 3'd0; special_i = 2'd0; nv_i = 1'b0;

        add(1'b0, 10'd127, 24'hFFFFFF, 3'b111, 2'b01, 3'b000, 2'b00, 1'b0, 32'h40000000, 5'b00001);
        add(1'b0, 10'd127, 24'h800000, 3'b001, 2'b11, 3'b001, 2'b00, 1'b0, 32'h3F7FFFFF, 5'b00001);
        add(1'b0, 10'd254, 24'hFFFFFF, 3'b111, 2'b01, 3'b000, 2'b00, 1'b0, 32'h7F800000, 5'b00101);
        add(1'b0, 10'd254, 24'hFFFFFF, 3'b111, 2'b01, 3'b001, 2'b00, 1'b0, 32'h7F7FFFFF, 5'b00101);
        add(1'b0, 10'd0,   24'h7FFFFF, 3'b011, 2'b01, 3'b000, 2'b00, 1'b0, 32'h00800000, 5'b00001);
        add(1'b1, 10'd127, 24'h800000, 3'b111, 2'b01, 3'b000, 2'b01, 1'b1, 32'h7FC00000, 5'b10000);
        add(1'b1, 10'd254, 24'hFFFFFF, 3'b111, 2'b01, 3'b010, 2'b00, 1'b0, 32'hFF800000, 5'b00101);
        add(1'b1, 10'd254, 24'hFFFFFF, 3'b111, 2'b01, 3'b011, 2'b00, 1'b0, 32'hFF7FFFFF, 5'b00101);
        add(1'b0, 10'd254, 24'hFFFFFF, 3'b111, 2'b01, 3'b011, 2'b00, 1'b0, 32'h7F800000, 5'b00101);
        add(1'b0, 10'd254, 24'hFFFFFF, 3'b111, 2'b01, 3'b010, 2'b00, 1'b0, 32'h7F7FFFFF, 5'b00101);
        add(1'b1, 10'd254, 24'hFFFFFF, 3'b111, 2'b01, 3'b100, 2'b00, 1'b0, 32'hFF800000, 5'b00101);
        add(1'b0, 10'd254, 24'hFFFFFF, 3'b111, 2'b01, 3'b101, 2'b00, 1'b0, 32'h7F800000, 5'b00101);
        add(1'b0, 10'd1,   24'h800000, 3'b001, 2'b11, 3'b001, 2'b00, 1'b0, 32'h007FFFFF, 5'b00011);
        add(1'b1, 10'd130, 24'hC00000, 3'b000, 2'b00, 3'b000, 2'b00, 1'b0, 32'hC1400000, 5'b00000);
        add(1'b0, 10'd130, 24'hC00000, 3'b000, 2'b10, 3'b000, 2'b00, 1'b0, 32'h41400000, 5'b00001);
        add(1'b1, 10'd100, 24'h900000, 3'b011, 2'b01, 3'b000, 2'b10, 1'b0, 32'hFF800000, 5'b00000);
        add(1'b1, 10'd100, 24'h900000, 3'b011, 2'b01, 3'b000, 2'b11, 1'b1, 32'h80000000, 5'b10000);
        add(1'b0, 10'h3FE, 24'h400000, 3'b010, 2'b00, 3'b000, 2'b00, 1'b0, 32'h00400000, 5'b00011);
        add(1'b0, 10'd0,   24'h000123, 3'b000, 2'b00, 3'b000, 2'b00, 1'b0, 32'h00000123, 5'b00000);
        add(1'b0, 10'd255, 24'h800000, 3'b000, 2'b00, 3'b000, 2'b00, 1'b0, 32'h7F800000, 5'b00101);
        add(1'b0, 10'd200, 24'hABCDEF, 3'b000, 2'b00, 3'b000, 2'b00, 1'b1, 32'h642BCDEF, 5'b10000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        check("reset_flags", {27'd0, fflags_o}, 32'd0);
        @(posedge clk); #1 reset_i = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, ready_o}, 32'd1);

        // Directed vectors, one beat at a time, with latency measured.
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1 drive(tbl[i]);
            @(posedge clk); #1 valid_i = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!valid_o && n < 8);
            check($sformatf("vec%0d_latency", i), n, 32'd2);
            check($sformatf("vec%0d_result", i), result_o, tbl[i].res);
            check($sformatf("vec%0d_flags", i), {27'd0, fflags_o}, {27'd0, tbl[i].fl});
        end

        // Randomized streaming with random backpressure.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            v = rand_vec();
            drive(v);
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1 valid_i = 1'b0; ready_i = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("random_drain_empty", q_res.size(), 32'd0);

        // Four back-to-back beats, downstream stalled in cycles 3-5.
        rdy_pat = 10'b1111100011;
        exp_rdy = 10'b1111100011;
        exp_vld = 10'b0111111100;
        for (int i = 0; i < 4; i++) begin
            bv[i]    = rand_vec();
            bv[i].sp = 2'b00;
        end
        k = 0;
        emitted = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            ready_i = rdy_pat[c];
            if (k < 4) drive(bv[k]);
            else valid_i = 1'b0;
            @(negedge clk);
            check($sformatf("burst_ready_c%0d", c + 1), {31'd0, ready_o}, {31'd0, exp_rdy[c]});
            check($sformatf("burst_valid_c%0d", c + 1), {31'd0, valid_o}, {31'd0, exp_vld[c]});
            if (valid_i && ready_o) k++;
            if (valid_o && ready_i) emitted++;
        end
        check("burst_accepted", k, 32'd4);
        check("burst_emitted", emitted, 32'd4);

        // Reset in the middle of a burst discards everything in flight.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            ready_i = 1'b1;
            drive(rand_vec());
        end
        @(posedge clk); #1 reset_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midreset_valid", {31'd0, valid_o}, 32'd0);
        @(posedge clk); #1 reset_i = 1'b0; valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("postreset_valid_c%0d", c), {31'd0, valid_o}, 32'd0);
            check($sformatf("postreset_ready_c%0d", c), {31'd0, ready_o}, 32'd1);
        end
        check("final_sb_empty", q_res.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
